// File: rtl/spi_controller_if.sv
// rtl/spi_controller_if.sv - request/status and SPI pin bundle for spi_controller
interface spi_controller_if;
   logic       start;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       sclk;
   logic       copi;
   logic       ncs;
   logic       busy;
   logic       done;

   // requester side: issues write requests, observes status and pins
   modport master (
      output start, addr, wdata,
      input  sclk, copi, ncs, busy, done
   );

   // controller side
   modport slave (
      input  start, addr, wdata,
      output sclk, copi, ncs, busy, done
   );
endinterface

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - mode-0 SPI write-frame controller, 16-bit {1, addr, wdata} frames
module spi_controller #(
   parameter int unsigned HALF_PERIOD = 4,
   parameter int unsigned CS_SETUP    = 4,
   parameter int unsigned CS_HOLD     = 4,
   parameter int unsigned CS_GAP      = 4
) (
   input logic       clk,
   input logic       rst_n,
   spi_controller_if.slave bus
);

   // every timed phase loads its length minus one and advances when the counter reaches zero
   localparam logic [7:0] HALF_LOAD  = 8'(HALF_PERIOD - 1);
   localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP - 1);
   localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD - 1);
   localparam logic [7:0] GAP_LOAD   = 8'(CS_GAP - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   state_t      state;
   logic [15:0] frame;
   logic [7:0]  cnt;
   logic [3:0]  bit_cnt;

   // frame sequencer: all pin and status outputs are registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         frame    <= '0;
         cnt      <= '0;
         bit_cnt  <= '0;
         bus.sclk <= 1'b0;
         bus.copi <= 1'b0;
         bus.ncs  <= 1'b1;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  // write flag is always set; first bit goes out together with ncs fall
                  frame    <= {1'b1, bus.addr, bus.wdata};
                  bus.copi <= 1'b1;
                  bus.ncs  <= 1'b0;
                  bus.busy <= 1'b1;
                  cnt      <= SETUP_LOAD;
                  bit_cnt  <= '0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == 8'd0) begin
                  cnt   <= HALF_LOAD;
                  state <= SHIFT;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            SHIFT: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else if (!bus.sclk) begin
                  bus.sclk <= 1'b1;
                  cnt      <= HALF_LOAD;
               end else begin
                  // falling edge: the only place copi moves while shifting
                  bus.sclk <= 1'b0;
                  if (bit_cnt == 4'd15) begin
                     bus.copi <= 1'b0;
                     bit_cnt  <= '0;
                     cnt      <= HOLD_LOAD;
                     state    <= HOLD;
                  end else begin
                     bus.copi <= frame[4'd14 - bit_cnt];
                     bit_cnt  <= bit_cnt + 4'd1;
                     cnt      <= HALF_LOAD;
                  end
               end
            end
            HOLD: begin
               if (cnt == 8'd0) begin
                  bus.ncs <= 1'b1;
                  cnt     <= GAP_LOAD;
                  state   <= GAP;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            GAP: begin
               if (cnt == 8'd0) begin
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - directed bench for spi_controller with a synchronized peripheral model
module tb_spi_controller;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   spi_controller_if bus0 ();
   spi_controller_if bus1 ();

   spi_controller dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   spi_controller #(
      .HALF_PERIOD (3),
      .CS_SETUP    (1),
      .CS_HOLD     (1),
      .CS_GAP      (1)
   ) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // free-running edge counter used as the time base for all latency checks
   always @(posedge clk) cyc <= cyc + 1;

   // peripheral model on dut0: 2-FF synchronizers, shift on synced rise, commit on synced ncs rise
   logic [2:0]  s_sclk = 3'b000;
   logic [2:0]  s_copi = 3'b000;
   logic [2:0]  s_ncs  = 3'b111;
   logic [15:0] pshift = '0;
   int          pcnt   = 0;
   logic [7:0]  pregs [0:127] = '{default: 8'h00};

   always @(posedge clk) begin
      s_sclk <= {s_sclk[1:0], bus0.sclk};
      s_copi <= {s_copi[1:0], bus0.copi};
      s_ncs  <= {s_ncs[1:0],  bus0.ncs};
      if (s_ncs[1]) begin
         if (!s_ncs[2] && pcnt == 16 && pshift[15])
            pregs[pshift[14:8]] <= pshift[7:0];
         pcnt <= 0;
      end else if (s_sclk[1] && !s_sclk[2]) begin
         pshift <= {pshift[14:0], s_copi[1]};
         pcnt   <= pcnt + 1;
      end
   end

   // pin monitor for both instances, sampled on the falling clk edge
   logic [1:0]  m_sclk, m_copi, m_ncs, m_done;
   logic [1:0]  p_sclk = 2'b00;
   logic [1:0]  p_copi = 2'b00;
   logic [1:0]  p_ncs  = 2'b11;
   int          e0 [2], nrise [2], ndone [2], nfr [2], stray [2], bad_copi [2];
   int          ncs_rel [2], done_rel [2];
   int          rise_rel [2][16];
   logic [15:0] word [2];
   logic [15:0] flog_word [2][8];
   int          flog_e0 [2][8];

   assign m_sclk = {bus1.sclk, bus0.sclk};
   assign m_copi = {bus1.copi, bus0.copi};
   assign m_ncs  = {bus1.ncs,  bus0.ncs};
   assign m_done = {bus1.done, bus0.done};

   initial begin
      for (int i = 0; i < 2; i++) begin
         e0[i] = 0; nrise[i] = 0; ndone[i] = 0; nfr[i] = 0; stray[i] = 0;
         bad_copi[i] = 0; ncs_rel[i] = 0; done_rel[i] = 0; word[i] = '0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst_n && m_copi[i] !== p_copi[i] && !(p_sclk[i] && !m_sclk[i]) && !(p_ncs[i] && !m_ncs[i]))
            bad_copi[i]++;
         if (!m_ncs[i] && p_ncs[i]) begin
            e0[i] = cyc; nrise[i] = 0; word[i] = '0;
         end
         if (m_sclk[i] && !p_sclk[i]) begin
            if (nrise[i] < 16) rise_rel[i][nrise[i]] = cyc - e0[i];
            word[i] = {word[i][14:0], m_copi[i]};
            nrise[i]++;
            if (m_ncs[i]) stray[i]++;
         end
         if (m_ncs[i] && !p_ncs[i]) begin
            ncs_rel[i] = cyc - e0[i];
            flog_word[i][nfr[i] % 8] = word[i];
            flog_e0[i][nfr[i] % 8]   = e0[i];
            nfr[i]++;
         end
         if (m_done[i]) begin
            done_rel[i] = cyc - e0[i];
            ndone[i]++;
         end
      end
      p_sclk = m_sclk;
      p_copi = m_copi;
      p_ncs  = m_ncs;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic send(input int i, input logic [6:0] a, input logic [7:0] d);
      if (i == 0) begin
         bus0.start = 1'b1; bus0.addr = a; bus0.wdata = d;
         tick(1);
         bus0.start = 1'b0;
      end else begin
         bus1.start = 1'b1; bus1.addr = a; bus1.wdata = d;
         tick(1);
         bus1.start = 1'b0;
      end
   endtask

   task automatic wait_done(input int i, input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (ndone[i] < target && n < budget) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(ndone[i] >= target), 32'd1);
   endtask

   logic [7:0] exp_regs [0:127] = '{default: 8'h00};
   logic [7:0] d033 [5] = '{8'hA5, 8'h5A, 8'hFF, 8'h01, 8'h7F};

   // directed sequence
   initial begin
      int tgt, f0, r;
      bus0.start = 1'b0; bus0.addr = '0; bus0.wdata = '0;
      bus1.start = 1'b0; bus1.addr = '0; bus1.wdata = '0;
      rst_n = 1'b0;
      tick(3);
      chk("rst_sclk", bus0.sclk, 0);
      chk("rst_copi", bus0.copi, 0);
      chk("rst_ncs",  bus0.ncs,  1);
      chk("rst_busy", bus0.busy, 0);
      chk("rst_done", bus0.done, 0);
      chk("rst_ncs1", bus1.ncs,  1);
      rst_n = 1'b1;
      tick(2);

      // default timing, addr 0x04 / data 0x80
      tgt = ndone[0] + 1;
      send(0, 7'h04, 8'h80);
      chk("acc_busy", bus0.busy, 1);
      chk("acc_ncs",  bus0.ncs,  0);
      chk("acc_copi", bus0.copi, 1);
      chk("acc_sclk", bus0.sclk, 0);
      wait_done(0, tgt, 300, "t032_timeout");
      chk("t032_busy_at_done", bus0.busy, 0);
      chk("t032_word",  word[0], 16'h8480);
      chk("t032_nrise", nrise[0], 16);
      for (int k = 0; k < 16; k++)
         chk($sformatf("t032_rise%0d", k), rise_rel[0][k], 8 + 8 * k);
      chk("t032_ncs_rise", ncs_rel[0], 136);
      chk("t032_done",     done_rel[0], 140);
      tick(1);
      chk("t032_done_pulse", bus0.done, 0);
      tick(2);
      exp_regs[4] = 8'h80;
      chk("t032_preg4", pregs[4], 8'h80);

      // loopback writes to registers 0..4
      for (int k = 0; k < 5; k++) begin
         tgt = ndone[0] + 1;
         send(0, 7'(k), d033[k]);
         wait_done(0, tgt, 300, "t033_timeout");
         tick(2);
         exp_regs[k] = d033[k];
         for (int j = 0; j < 8; j++)
            chk($sformatf("t033_w%0d_reg%0d", k, j), pregs[j], exp_regs[j]);
      end

      // start held high for 200 cycles, addr changes during busy
      tgt = ndone[0] + 2;
      f0  = nfr[0];
      bus0.start = 1'b1; bus0.addr = 7'h11; bus0.wdata = 8'h22;
      tick(20);
      bus0.addr = 7'h33;
      tick(180);
      bus0.start = 1'b0;
      wait_done(0, tgt, 400, "t034_timeout");
      tick(20);
      chk("t034_frames", nfr[0] - f0, 2);
      chk("t034_dones",  ndone[0], tgt);
      chk("t034_word0",  flog_word[0][f0 % 8], 16'h9122);
      chk("t034_word1",  flog_word[0][(f0 + 1) % 8], 16'hB322);
      chk("t034_gap",    flog_e0[0][(f0 + 1) % 8] - flog_e0[0][f0 % 8], 141);
      chk("t034_reg11",  pregs[7'h11], 8'h22);
      chk("t034_reg33",  pregs[7'h33], 8'h22);

      // reset abort mid-frame
      bus0.addr = 7'h05; bus0.wdata = 8'hC3; bus0.start = 1'b1;
      @(posedge clk);
      #1 bus0.start = 1'b0;
      repeat (49) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("t035_ncs",  bus0.ncs,  1);
      chk("t035_sclk", bus0.sclk, 0);
      chk("t035_busy", bus0.busy, 0);
      chk("t035_copi", bus0.copi, 0);
      tick(3);
      r = nrise[0];
      rst_n = 1'b1;
      tick(200);
      chk("t035_no_rises", nrise[0], r);
      chk("t035_ncs_idle", bus0.ncs, 1);
      chk("t035_reg5",     pregs[5], 8'h00);
      tgt = ndone[0] + 1;
      send(0, 7'h06, 8'h3C);
      wait_done(0, tgt, 300, "t035_timeout");
      tick(2);
      chk("t035_word",  word[0], 16'h863C);
      chk("t035_nrise", nrise[0], 16);
      chk("t035_reg6",  pregs[6], 8'h3C);
      chk("t035_reg5b", pregs[5], 8'h00);

      // minimum timing instance
      tgt = ndone[1] + 1;
      send(1, 7'h7F, 8'h00);
      wait_done(1, tgt, 200, "t036_timeout");
      chk("t036_word",  word[1], 16'hFF00);
      chk("t036_nrise", nrise[1], 16);
      for (int k = 0; k < 16; k++)
         chk($sformatf("t036_rise%0d", k), rise_rel[1][k], 4 + 6 * k);
      chk("t036_ncs_rise", ncs_rel[1], 98);
      chk("t036_done",     done_rel[1], 99);

      chk("stray_sclk0", stray[0], 0);
      chk("stray_sclk1", stray[1], 0);
      chk("copi_stable0", bad_copi[0], 0);
      chk("copi_stable1", bad_copi[1], 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 The block SHALL have parameter HALF_PERIOD, default 4: clk cycles per SCLK phase, legal range 3..255.
REQ-002 The block SHALL have parameter CS_SETUP, default 4: clk cycles from NCS fall to the start of the first SCLK low phase, legal range 1..255.
REQ-003 The block SHALL have parameter CS_HOLD, default 4: clk cycles from the last SCLK fall to NCS rise, legal range 1..255.
REQ-004 The block SHALL have parameter CS_GAP, default 4: clk cycles NCS stays high before `done`, legal range 1..255.
REQ-005 Port `clk`, input, 1 bit: the single clock; all logic SHALL run on its rising edge.
REQ-006 Port `rst_n`, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port `start`, input, 1 bit: request a write frame, sampled only in IDLE.
REQ-008 Port `addr`, input, 7 bits: target register address, latched at accept.
REQ-009 Port `wdata`, input, 8 bits: write data, latched at accept.
REQ-010 Port `sclk`, output, 1 bit: serial clock, idles low (mode 0).
REQ-011 Port `copi`, output, 1 bit: serial data, MSB first.
REQ-012 Port `ncs`, output, 1 bit: active-low chip select.
REQ-013 Port `busy`, output, 1 bit: high from accept until the end of the frame.
REQ-014 Port `done`, output, 1 bit: one-cycle pulse at the end of the frame.

Function
REQ-015 Frame SHALL be 16 bits {1'b1, addr, wdata}; bit 15 (write flag) SHALL always be 1.
REQ-016 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, GAP; all outputs SHALL be registered.
REQ-017 IDLE with start=1 at edge E0: latch frame; busy<=1; ncs<=0; copi<=frame[15]; go to SETUP.
REQ-018 `start` SHALL be ignored while busy=1 (no queuing, latched frame unchanged).
REQ-019 SETUP SHALL last CS_SETUP cycles, then the block SHALL enter SHIFT with sclk=0.
REQ-020 SHIFT: each bit SHALL be a low phase of HALF_PERIOD cycles followed by a high phase of HALF_PERIOD cycles.
REQ-021 Rise of bit k (k=0..15, bit 15-k of the frame) SHALL occur at edge E0+CS_SETUP+HALF_PERIOD*(2k+1).
REQ-022 `copi` SHALL change only on the edge where sclk falls, or at E0 for the first bit, so that it is stable for at least HALF_PERIOD cycles around every rise.
REQ-023 After the 16th high phase, sclk SHALL fall at edge E0+CS_SETUP+32*HALF_PERIOD, copi SHALL be driven to 0, and the FSM SHALL go to HOLD.
REQ-024 HOLD SHALL last CS_HOLD cycles with ncs=0 and sclk=0; then ncs<=1 and the FSM SHALL go to GAP.
REQ-025 GAP SHALL last CS_GAP cycles; on its final edge: done<=1 for exactly one cycle, busy<=0, state<=IDLE.
REQ-026 The earliest next accept SHALL be the edge after done is asserted (start high during the done cycle is accepted).
REQ-027 Bit and phase counters SHALL wrap only under FSM control; exactly 16 rising sclk edges SHALL occur per frame, never more or less.
REQ-028 Outside SHIFT, sclk SHALL be 0; outside SETUP/SHIFT/HOLD, ncs SHALL be 1.

Reset
REQ-029 While rst_n=0, asynchronously: sclk=0, copi=0, ncs=1, busy=0, done=0, state=IDLE, frame register=0, counters=0.
REQ-030 Reset mid-frame SHALL abort immediately (ncs rises in the same instant) with no further sclk edges; the partial frame SHALL NOT complete after release.
REQ-031 After rst_n deasserts, the first accept SHALL be possible on the first clk edge at which start=1.

Verification
REQ-032 Defaults, addr=0x04, wdata=0x80: ncs falls at E0; 16 sclk rises at E0+8, E0+16, ... E0+128; sampled bits = 0x8480; ncs rises at E0+136; done pulses at E0+140.
REQ-033 Loopback through a 2-FF-synchronized SPI peripheral model, write of addr 0x00..0x04 with data 0xA5/0x5A/0xFF/0x01/0x7F: each target register updates to its value, all others unchanged.
REQ-034 start held high for 200 cycles: exactly one frame for the first accept; a second frame begins at the done+1 edge; addr changes during busy do not alter the shifted bits.
REQ-035 rst_n low at E0+50: ncs=1, sclk=0, busy=0 immediately; the peripheral model registers are unchanged; a fresh frame after release is correct.
REQ-036 HALF_PERIOD=3, CS_SETUP=CS_HOLD=CS_GAP=1, addr=0x7F, wdata=0x00: rises at E0+4+6k; done at E0+1+96+1+1; sampled bits = 0xFF00.
